valu_issue_port: RTL and testbench



---
 rtl/valu_issue_port.sv | 113 +++++++++++
 tb/tb_valu_issue_port.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/valu_issue_port.sv
// Issue-side FIFO and valid/ready initiator for the VALU, with a registered, ID-tagged writeback.
// Build option: define VALU_ISSUE_SILENCE_EN to force the operand outputs to zero while valu_valid_o is low.
module valu_issue_port #(
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     issue_valid_i,
   output logic                     issue_ready_o,
   input  logic [31:0]              issue_operand_a_i,
   input  logic [31:0]              issue_operand_b_i,
   input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
   output logic                     valu_valid_o,
   input  logic                     valu_ready_i,
   output logic [31:0]              valu_operand_a_o,
   output logic [31:0]              valu_operand_b_o,
   input  logic [31:0]              valu_result_i,
   output logic                     wb_valid_o,
   output logic [31:0]              wb_result_o,
   output logic [TRANS_ID_BITS-1:0] wb_trans_id_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [31:0]              r_mem_a  [DEPTH];
   logic [31:0]              r_mem_b  [DEPTH];
   logic [TRANS_ID_BITS-1:0] r_mem_id [DEPTH];
   logic [PTR_W-1:0]         r_wptr;
   logic [PTR_W-1:0]         r_rptr;
   logic [CNT_W-1:0]         r_count;
   logic                     r_wb_valid;
   logic [31:0]              r_wb_result;
   logic [TRANS_ID_BITS-1:0] r_wb_id;

   logic w_push;
   logic w_fire;
   logic [31:0] w_head_a;
   logic [31:0] w_head_b;

   // Ready looks only at the registered count, so a pop never opens a slot in the same cycle.
   assign issue_ready_o = (r_count < FULL_CNT) && !flush_i;
   assign valu_valid_o  = (r_count != '0);
   assign w_push        = issue_valid_i && issue_ready_o;
   assign w_fire        = valu_valid_o && valu_ready_i && !flush_i;

   assign w_head_a = r_mem_a[r_rptr];
   assign w_head_b = r_mem_b[r_rptr];

`ifdef VALU_ISSUE_SILENCE_EN
   assign valu_operand_a_o = valu_valid_o ? w_head_a : 32'd0;
   assign valu_operand_b_o = valu_valid_o ? w_head_b : 32'd0;
`else
   assign valu_operand_a_o = w_head_a;
   assign valu_operand_b_o = w_head_b;
`endif

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_mem_a[gi]  <= '0;
               r_mem_b[gi]  <= '0;
               r_mem_id[gi] <= '0;
            end else if (w_push && (r_wptr == PTR_W'(gi))) begin
               r_mem_a[gi]  <= issue_operand_a_i;
               r_mem_b[gi]  <= issue_operand_b_i;
               r_mem_id[gi] <= issue_trans_id_i;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_fire) r_rptr <= r_rptr + PTR_W'(1);
         if (w_push && !w_fire)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_fire) r_count <= r_count - CNT_W'(1);
      end
   end

   // Writeback data holds between pulses; w_fire already excludes the flush cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wb_valid  <= 1'b0;
         r_wb_result <= '0;
         r_wb_id     <= '0;
      end else begin
         r_wb_valid <= w_fire;
         if (w_fire) begin
            r_wb_result <= valu_result_i;
            r_wb_id     <= r_mem_id[r_rptr];
         end
      end
   end

   assign wb_valid_o    = r_wb_valid;
   assign wb_result_o   = r_wb_result;
   assign wb_trans_id_o = r_wb_id;

endmodule

// File: tb/tb_valu_issue_port.sv
// Scoreboard bench for valu_issue_port: directed scenarios followed by randomized traffic,
// checked against a queue-based behavioural model.
module tb_valu_issue_port;

   localparam int DEPTH = 2;
   localparam int TIDW  = 3;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            issue_valid_i;
   logic            issue_ready_o;
   logic [31:0]     issue_operand_a_i;
   logic [31:0]     issue_operand_b_i;
   logic [TIDW-1:0] issue_trans_id_i;
   logic            valu_valid_o;
   logic            valu_ready_i;
   logic [31:0]     valu_operand_a_o;
   logic [31:0]     valu_operand_b_o;
   logic [31:0]     valu_result_i;
   logic            wb_valid_o;
   logic [31:0]     wb_result_o;
   logic [TIDW-1:0] wb_trans_id_o;

   always #5 clk_i = ~clk_i;

   // Execute-stage VALU stand-in: adds the presented operands.
   assign valu_result_i = valu_operand_a_o + valu_operand_b_o;

   valu_issue_port #(.DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .flush_i           (flush_i),
      .issue_valid_i     (issue_valid_i),
      .issue_ready_o     (issue_ready_o),
      .issue_operand_a_i (issue_operand_a_i),
      .issue_operand_b_i (issue_operand_b_i),
      .issue_trans_id_i  (issue_trans_id_i),
      .valu_valid_o      (valu_valid_o),
      .valu_ready_i      (valu_ready_i),
      .valu_operand_a_o  (valu_operand_a_o),
      .valu_operand_b_o  (valu_operand_b_o),
      .valu_result_i     (valu_result_i),
      .wb_valid_o        (wb_valid_o),
      .wb_result_o       (wb_result_o),
      .wb_trans_id_o     (wb_trans_id_o)
   );

   typedef struct packed {
      logic [31:0]     a;
      logic [31:0]     b;
      logic [TIDW-1:0] id;
   } op_t;

   typedef struct packed {
      logic [31:0]     res;
      logic [TIDW-1:0] id;
   } wb_t;

   op_t         fifo_q[$];
   wb_t         wb_q[$];
   logic [31:0] slot_a [DEPTH];
   logic [31:0] slot_b [DEPTH];
   int unsigned n_push = 0;
   int unsigned n_pop  = 0;
   logic [31:0] last_res = '0;
   logic [TIDW-1:0] last_id = '0;
   int n_tests = 0;
   int n_fail  = 0;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_a[i] = '0;
         slot_b[i] = '0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: check the state produced by the last edge, then advance the model
   // with the handshakes that the next edge will complete.
   always @(negedge clk_i) begin
      op_t         op;
      wb_t         w;
      logic        push;
      logic        fire;
      logic [31:0] ea;
      logic [31:0] eb;
      #1;
      if (rst_ni) begin
         check("wb_valid", 32'(wb_valid_o), 32'(wb_q.size() != 0));
         if (wb_q.size() != 0) begin
            w        = wb_q.pop_front();
            last_res = w.res;
            last_id  = w.id;
            $display("[TB] wb   id=%0d res=0x%08h dut_id=%0d dut_res=0x%08h", w.id, w.res, wb_trans_id_o, wb_result_o);
         end
         check("wb_result", wb_result_o, last_res);
         check("wb_trans_id", 32'(wb_trans_id_o), 32'(last_id));
         check("issue_ready", 32'(issue_ready_o), 32'((fifo_q.size() < DEPTH) && !flush_i));
         check("valu_valid", 32'(valu_valid_o), 32'(fifo_q.size() != 0));
         if (fifo_q.size() != 0) begin
            ea = fifo_q[0].a;
            eb = fifo_q[0].b;
         end else begin
`ifdef VALU_ISSUE_SILENCE_EN
            ea = '0;
            eb = '0;
`else
            ea = slot_a[n_pop % DEPTH];
            eb = slot_b[n_pop % DEPTH];
`endif
         end
         check("operand_a", valu_operand_a_o, ea);
         check("operand_b", valu_operand_b_o, eb);

         push = issue_valid_i && (fifo_q.size() < DEPTH) && !flush_i;
         fire = (fifo_q.size() != 0) && valu_ready_i && !flush_i;
         if (flush_i) begin
            fifo_q.delete();
            n_push = 0;
            n_pop  = 0;
            $display("[TB] flush");
         end else begin
            if (fire) begin
               op = fifo_q.pop_front();
               wb_q.push_back('{res: op.a + op.b, id: op.id});
               n_pop++;
            end
            if (push) begin
               fifo_q.push_back('{a: issue_operand_a_i, b: issue_operand_b_i, id: issue_trans_id_i});
               slot_a[n_push % DEPTH] = issue_operand_a_i;
               slot_b[n_push % DEPTH] = issue_operand_b_i;
               n_push++;
               $display("[TB] push id=%0d a=0x%08h b=0x%08h", issue_trans_id_i, issue_operand_a_i, issue_operand_b_i);
            end
         end
      end
   end

   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [TIDW-1:0] id, input logic rdy, input logic fl);
      @(negedge clk_i);
      issue_valid_i     = v;
      issue_operand_a_i = a;
      issue_operand_b_i = b;
      issue_trans_id_i  = id;
      valu_ready_i      = rdy;
      flush_i           = fl;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, '0, rdy, 1'b0);
   endtask

   initial begin
      rst_ni            = 1'b0;
      flush_i           = 1'b0;
      issue_valid_i     = 1'b0;
      issue_operand_a_i = '0;
      issue_operand_b_i = '0;
      issue_trans_id_i  = '0;
      valu_ready_i      = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      idle(2, 1'b1);

      // Single op: valid at N+1, writeback 0x8/id 2 at N+2.
      step(1'b1, 32'h5, 32'h3, 3'd2, 1'b1, 1'b0);
      idle(4, 1'b1);

      // Back-pressure: fill, hold while full, then release.
      step(1'b1, 32'h11, 32'h22, 3'd1, 1'b0, 1'b0);
      step(1'b1, 32'h33, 32'h44, 3'd2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h55, 32'h66, 3'd3, 1'b0, 1'b0);
      idle(4, 1'b1);

      // Streaming across pointer wrap.
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'(i * 16 + 1), 32'(i * 256 + 7), TIDW'(i), 1'b1, 1'b0);
      idle(4, 1'b1);

      // Full with simultaneous pop: rejected that cycle, accepted the next.
      step(1'b1, 32'hA0, 32'h01, 3'd1, 1'b0, 1'b0);
      step(1'b1, 32'hB0, 32'h02, 3'd2, 1'b0, 1'b0);
      step(1'b1, 32'hC0, 32'h03, 3'd3, 1'b1, 1'b0);
      step(1'b1, 32'hC0, 32'h03, 3'd3, 1'b1, 1'b0);
      idle(4, 1'b1);

      // Flush with two queued ops and a push attempt in the flush cycle.
      step(1'b1, 32'hD0, 32'h04, 3'd4, 1'b0, 1'b0);
      step(1'b1, 32'hE0, 32'h05, 3'd5, 1'b0, 1'b0);
      step(1'b1, 32'hF0, 32'h06, 3'd6, 1'b1, 1'b1);
      idle(4, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom, TIDW'($urandom_range(0, 7)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      idle(6, 1'b1);

      @(negedge clk_i);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
